fifo_rd_arb: RTL and testbench

- Read-side scheduler that shares one synchronous FIFO read port between two consumers.
- Each consumer requests a burst of N bytes. The block grants round-robin, then waits a settle delay so the FIFO status flags can update.
- It then drives fifo_rd_en for exactly N reads, stalling while the FIFO is empty.
- It sits between the FIFO IP read port and the consumer logic, in the FIFO read clock domain.

---
 rtl/fifo_rd_arb.sv | 88 ++++++++
 tb/tb_fifo_rd_arb.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_arb.sv
// fifo_rd_arb: round-robin burst scheduler sharing one FIFO read port between two consumers
module fifo_rd_arb #(
  parameter int DATA_W = 8,
  parameter int LEN_W = 8,
  parameter int SETTLE_CYC = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [LEN_W-1:0]  len0,
  input  logic [LEN_W-1:0]  len1,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  output logic              busy,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_last
);
  localparam int CW = SETTLE_CYC > 1 ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0] CNT_END = CW'(SETTLE_CYC > 0 ? SETTLE_CYC - 1 : 0);
  typedef enum logic [1:0] {IDLE, SETTLE, BURST, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] gnt_q, gnt_d;
  logic last_q, last_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
  logic win1;
  always_comb begin
    win1 = req[1] & (~req[0] | ~last_q);
    fifo_rd_en = state_q == BURST && !fifo_empty && rem_q != '0;
    state_d = state_q;
    gnt_d = gnt_q;
    last_d = last_q;
    rem_d = rem_q;
    cnt_d = cnt_q;
    rd_valid_d = fifo_rd_en;
    rd_last_d = fifo_rd_en && rem_q == LEN_W'(1);
    case (state_q)
      IDLE: if (req != 2'b00) begin
        state_d = SETTLE_CYC == 0 ? BURST : SETTLE;
        gnt_d = win1 ? 2'b10 : 2'b01;
        last_d = win1;
        rem_d = win1 ? len1 : len0;
      end
      SETTLE: begin
        cnt_d = cnt_q == CNT_END ? '0 : cnt_q + 1'b1;
        state_d = cnt_q == CNT_END ? BURST : SETTLE;
      end
      BURST: begin
        rem_d = rem_q - LEN_W'(fifo_rd_en);
        state_d = rem_d == '0 ? DONE : BURST;
      end
      default: begin
        state_d = IDLE;
        gnt_d = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q <= '0;
      last_q <= 1'b1;
      rem_q <= '0;
      cnt_q <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      last_q <= last_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q <= rd_last_d;
    end
  end
  assign gnt = gnt_q;
  assign done = state_q == DONE ? gnt_q : 2'b00;
  assign busy = state_q != IDLE;
  assign rd_data = fifo_dout;
  assign rd_valid = rd_valid_q;
  assign rd_last = rd_last_q;
endmodule

// File: tb/tb_fifo_rd_arb.sv
// tb_fifo_rd_arb: vector table plus scoreboard bench for the FIFO read scheduler
module tb_fifo_rd_arb;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, flush;
  logic [1:0] req, gnt, done;
  logic [7:0] len0, len1, fifo_dout, rd_data;
  logic busy, fifo_empty, fifo_rd_en, rd_valid, rd_last;
  logic [1:0] req_z, gnt_z, done_z;
  logic [7:0] len0_z, rd_data_z;
  logic busy_z, fifo_rd_en_z, rd_valid_z, rd_last_z;
  logic [7:0] mem [0:255];
  int pushed = 0;
  int popped = 0;
  int staged = 0;
  int seq = 1;
  int checks = 0;
  int errs = 0;
  int nvalid = 0;
  int n0 = 0;
  typedef struct { logic [7:0] d; logic last; } exp_t;
  exp_t sb[$];
  logic [7:0] model[$];
  typedef struct { logic [1:0] req; logic [7:0] l0; logic [7:0] l1; int nb; logic [1:0] g; int n; } vec_t;
  vec_t v[8];
  assign fifo_empty = pushed == popped;
  always @(posedge clk) begin
    if (flush) popped <= pushed;
    else if (fifo_rd_en) begin
      fifo_dout <= mem[8'(popped)];
      popped <= popped + 1;
    end
  end
  fifo_rd_arb u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .len0(len0), .len1(len1),
    .gnt(gnt), .done(done), .busy(busy), .fifo_dout(fifo_dout),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_last(rd_last)
  );
  fifo_rd_arb #(.SETTLE_CYC(0)) u_z (
    .clk(clk), .rst_n(rst_n), .req(req_z), .len0(len0_z), .len1(8'd0),
    .gnt(gnt_z), .done(done_z), .busy(busy_z), .fifo_dout(8'h5A),
    .fifo_empty(1'b0), .fifo_rd_en(fifo_rd_en_z), .rd_data(rd_data_z),
    .rd_valid(rd_valid_z), .rd_last(rd_last_z)
  );
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic stage(input int n);
    for (int i = 0; i < n; i++) begin
      mem[8'(pushed + staged)] = 8'(seq);
      model.push_back(8'(seq));
      seq++;
      staged++;
    end
  endtask
  task automatic commit(input int n);
    pushed += n;
    staged -= n;
  endtask
  task automatic expect_burst(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.d = model.pop_front();
      e.last = i == n - 1;
      sb.push_back(e);
    end
  endtask
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (rd_valid) begin
      nvalid++;
      if (sb.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_rd_valid data %0h expected no word", rd_data);
      end else begin
        e = sb.pop_front();
        check("rd_data", rd_data, e.d);
        check("rd_last", rd_last, e.last);
      end
    end else if (rd_last) check("rd_last_without_valid", rd_last, 0);
    if (fifo_rd_en) check("read_while_empty", fifo_empty, 0);
    if (done != 2'b00) check("done_vs_gnt", done, gnt);
  endtask
  function automatic bit cond(input int w);
    case (w)
      0: return gnt != 2'b00;
      1: return done != 2'b00;
      2: return !busy;
      3: return fifo_rd_en;
      default: return nvalid - n0 >= 2;
    endcase
  endfunction
  task automatic wait_for(input int w, input string nm);
    int n = 0;
    while (!cond(w) && n < 300) begin
      tick();
      n++;
    end
    if (!cond(w)) begin
      checks++;
      errs++;
      $display("FAIL %s timeout got %0d cycles expected under 300", nm, n);
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog got no finish expected finish");
    $fatal(1);
  end
  initial begin
    v[0] = '{2'b11, 8'd2, 8'd2, 8, 2'b01, 2};
    v[1] = '{2'b11, 8'd2, 8'd2, 0, 2'b10, 2};
    v[2] = '{2'b11, 8'd2, 8'd2, 0, 2'b01, 2};
    v[3] = '{2'b11, 8'd2, 8'd2, 0, 2'b10, 2};
    v[4] = '{2'b10, 8'd0, 8'd3, 3, 2'b10, 3};
    v[5] = '{2'b11, 8'd1, 8'd5, 1, 2'b01, 1};
    v[6] = '{2'b01, 8'd0, 8'd0, 1, 2'b01, 0};
    v[7] = '{2'b10, 8'd0, 8'd1, 0, 2'b10, 1};
    rst_n = 1'b0;
    flush = 1'b0;
    req = 2'b00;
    len0 = 8'd0;
    len1 = 8'd0;
    req_z = 2'b00;
    len0_z = 8'd0;
    tick();
    tick();
    check("rst_gnt", gnt, 2'b00);
    check("rst_busy", busy, 0);
    check("rst_done", done, 2'b00);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_gnt_z", gnt_z, 2'b00);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_for(2, "row_idle");
      stage(v[k].nb);
      commit(v[k].nb);
      expect_burst(v[k].n);
      req = v[k].req;
      len0 = v[k].l0;
      len1 = v[k].l1;
      n0 = nvalid;
      wait_for(0, "row_gnt");
      check($sformatf("row%0d_gnt", k), gnt, v[k].g);
      wait_for(1, "row_done");
      check($sformatf("row%0d_done", k), done, v[k].g);
      check($sformatf("row%0d_reads", k), nvalid - n0, v[k].n);
    end
    req = 2'b00;
    wait_for(2, "a_idle");
    stage(4);
    commit(4);
    expect_burst(4);
    req = 2'b01;
    len0 = 8'd4;
    tick();
    check("a_gnt", gnt, 2'b01);
    req = 2'b00;
    len0 = 8'd99;
    for (int i = 1; i <= 13; i++) begin
      tick();
      check($sformatf("a_rd_en_c%0d", i), fifo_rd_en, i >= 10);
    end
    tick();
    check("a_end_rd_en", fifo_rd_en, 0);
    check("a_done", done, 2'b01);
    check("a_rd_last", rd_last, 1);
    tick();
    check("a_gnt_clear", gnt, 2'b00);
    check("a_busy_clear", busy, 0);
    stage(5);
    commit(2);
    expect_burst(5);
    req = 2'b10;
    len1 = 8'd5;
    n0 = nvalid;
    wait_for(0, "b_gnt");
    check("b_gnt", gnt, 2'b10);
    req = 2'b00;
    wait_for(4, "b_first_two");
    begin
      int bad = 0;
      for (int i = 0; i < 20; i++) begin
        tick();
        bad += int'(fifo_rd_en);
      end
      check("b_stall_reads", bad, 0);
    end
    check("b_busy_stalled", busy, 1);
    commit(3);
    wait_for(1, "b_done");
    check("b_done", done, 2'b10);
    check("b_reads", nvalid - n0, 5);
    wait_for(2, "c_idle");
    stage(6);
    commit(6);
    expect_burst(6);
    req = 2'b01;
    len0 = 8'd6;
    wait_for(3, "c_rd_en");
    tick();
    rst_n = 1'b0;
    req = 2'b00;
    flush = 1'b1;
    tick();
    check("c_gnt", gnt, 2'b00);
    check("c_busy", busy, 0);
    check("c_rd_valid", rd_valid, 0);
    check("c_rd_en", fifo_rd_en, 0);
    rst_n = 1'b1;
    flush = 1'b0;
    sb.delete();
    model.delete();
    req = 2'b11;
    len0 = 8'd0;
    len1 = 8'd0;
    tick();
    check("c_tie_after_reset", gnt, 2'b01);
    req = 2'b00;
    wait_for(1, "c_done");
    wait_for(2, "c_idle_end");
    req_z = 2'b01;
    len0_z = 8'd3;
    tick();
    check("z_gnt", gnt_z, 2'b01);
    check("z_rd_en_0", fifo_rd_en_z, 1);
    req_z = 2'b00;
    tick();
    check("z_rd_en_1", fifo_rd_en_z, 1);
    tick();
    check("z_rd_en_2", fifo_rd_en_z, 1);
    tick();
    check("z_rd_en_3", fifo_rd_en_z, 0);
    check("z_done", done_z, 2'b01);
    check("z_last", {rd_valid_z, rd_last_z}, 2'b11);
    check("z_data", rd_data_z, 8'h5A);
    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end
endmodule
